// File: rtl/codificador_instrucao.sv
// Encodes ALU-operation requests into RV32I instruction words and streams them out
// through a small FIFO, tagging each word with its instruction-memory address.
module codificador_instrucao #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter logic [4:0]  OPAND     = 5'd0,
    parameter logic [4:0]  OPOR      = 5'd1,
    parameter logic [4:0]  OPADD     = 5'd3,
    parameter logic [4:0]  OPSUB     = 5'd4,
    parameter logic [4:0]  OPSLT     = 5'd5,
    parameter logic [4:0]  OPLUI     = 5'd12
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic        iStart,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic [4:0]  iOp,
    input  logic        iFmtI,
    input  logic [4:0]  iRd,
    input  logic [4:0]  iRs1,
    input  logic [4:0]  iRs2,
    input  logic [19:0] iImm,
    output logic        oOutValid,
    input  logic        iOutReady,
    output logic [31:0] oWord,
    output logic [31:0] oAddr,
    output logic        oErr,
    output logic [7:0]  oErrCount
);
    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0] FULL_CNT = (CW+1)'(DEPTH);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    logic [31:0]   mem_word [DEPTH];
    logic [31:0]   mem_addr [DEPTH];
    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [CW:0]   count;
    logic [31:0]   next_addr;

    logic [31:0] enc_word;
    logic        supported;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    always_comb begin
        supported = 1'b1;
        funct3    = 3'b000;
        funct7    = 7'b0000000;
        enc_word  = 32'h0;
        case (iOp)
            OPADD: funct3 = 3'b000;
            OPSUB: begin
                funct3 = 3'b000;
                funct7 = 7'b0100000;
                // There is no SUBI in RV32I
                if (iFmtI) supported = 1'b0;
            end
            OPSLT: funct3 = 3'b010;
            OPOR:  funct3 = 3'b110;
            OPAND: funct3 = 3'b111;
            OPLUI: funct3 = 3'b000;
            default: supported = 1'b0;
        endcase
        if (iOp == OPLUI)
            enc_word = {iImm[19:0], iRd, OPC_LUI};
        else if (iFmtI)
            enc_word = {iImm[11:0], iRs1, funct3, iRd, OPC_I};
        else
            enc_word = {funct7, iRs2, iRs1, funct3, iRd, OPC_R};
    end

    logic accept, push, pop;
    assign oReqReady = (count != FULL_CNT);
    assign oOutValid = (count != '0);
    assign accept    = iReqValid & oReqReady & ~iStart;
    assign push      = accept & supported;
    assign pop       = oOutValid & iOutReady;
    assign oWord     = mem_word[rd_ptr];
    assign oAddr     = mem_addr[rd_ptr];

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            next_addr <= BASE_ADDR;
            oErr      <= 1'b0;
            oErrCount <= 8'd0;
        end else if (iStart) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            next_addr <= BASE_ADDR;
            oErr      <= 1'b0;
            oErrCount <= 8'd0;
        end else begin
            oErr <= accept & ~supported;
            if (accept && !supported && oErrCount != 8'hFF)
                oErrCount <= oErrCount + 8'd1;
            if (push) begin
                wr_ptr    <= wr_ptr + CW'(1);
                next_addr <= next_addr + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + CW'(1);
            if (push && !pop)
                count <= count + (CW+1)'(1);
            else if (pop && !push)
                count <= count - (CW+1)'(1);
        end
    end

    // Storage carries no reset: entries are only read once count says they are valid
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem_word[wr_ptr] <= enc_word;
            mem_addr[wr_ptr] <= next_addr;
        end
    end
endmodule

// File: tb/tb_codificador_instrucao.sv
// Directed bench for codificador_instrucao with hand-computed RV32I encodings.
module tb_codificador_instrucao;
    localparam logic [4:0] OPAND = 5'd0, OPOR = 5'd1, OPADD = 5'd3, OPSUB = 5'd4,
                           OPSLT = 5'd5, OPLUI = 5'd12, OPNULL = 5'd31;

    logic        iCLK = 1'b0, iRSTn = 1'b0, iStart = 1'b0, iReqValid = 1'b0;
    logic        oReqReady, iFmtI = 1'b0, oOutValid, iOutReady = 1'b0, oErr;
    logic [4:0]  iOp = 5'd0, iRd = 5'd0, iRs1 = 5'd0, iRs2 = 5'd0;
    logic [19:0] iImm = 20'd0;
    logic [31:0] oWord, oAddr;
    logic [7:0]  oErrCount;

    int checks = 0;
    int failures = 0;

    codificador_instrucao dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .iReqValid(iReqValid),
        .oReqReady(oReqReady), .iOp(iOp), .iFmtI(iFmtI), .iRd(iRd), .iRs1(iRs1),
        .iRs2(iRs2), .iImm(iImm), .oOutValid(oOutValid), .iOutReady(iOutReady),
        .oWord(oWord), .oAddr(oAddr), .oErr(oErr), .oErrCount(oErrCount)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [4:0] op, input logic fmt, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm);
        iOp = op; iFmtI = fmt; iRd = rd; iRs1 = rs1; iRs2 = rs2; iImm = imm;
    endtask

    task automatic send(input logic [4:0] op, input logic fmt, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm);
        set_req(op, fmt, rd, rs1, rs2, imm);
        iReqValid = 1'b1;
        tick();
        iReqValid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] word, input logic [31:0] addr);
        check({tag, "_valid"}, {31'd0, oOutValid}, 32'd1);
        check({tag, "_word"}, oWord, word);
        check({tag, "_addr"}, oAddr, addr);
        iOutReady = 1'b1;
        tick();
        iOutReady = 1'b0;
    endtask

    task automatic start_pulse;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_valid", {31'd0, oOutValid}, 32'd0);
        check("rst_ready", {31'd0, oReqReady}, 32'd1);
        check("rst_err", {31'd0, oErr}, 32'd0);
        check("rst_errcnt", {24'd0, oErrCount}, 32'd0);
        iRSTn = 1'b1;
        tick();

        // Empty + push: no passthrough in the accept cycle, visible the next
        set_req(OPADD, 1'b0, 5'd3, 5'd1, 5'd2, 20'd0);
        iReqValid = 1'b1;
        #2 check("add_no_bypass", {31'd0, oOutValid}, 32'd0);
        tick();
        iReqValid = 1'b0;
        pop_check("add", 32'h002081B3, 32'h0040_0000);
        check("empty_after_pop", {31'd0, oOutValid}, 32'd0);

        start_pulse();
        send(OPSUB, 1'b0, 5'd5, 5'd6, 5'd7, 20'd0);
        send(OPADD, 1'b1, 5'd1, 5'd0, 5'd0, 20'h00FFF);
        pop_check("sub", 32'h407302B3, 32'h0040_0000);
        pop_check("addi", 32'hFFF00093, 32'h0040_0004);

        send(OPLUI, 1'b1, 5'd10, 5'd0, 5'd0, 20'h12345);
        send(OPOR, 1'b0, 5'd1, 5'd2, 5'd3, 20'd0);
        send(OPAND, 1'b1, 5'd4, 5'd5, 5'd0, 20'h000F0);
        pop_check("lui", 32'h12345537, 32'h0040_0008);
        pop_check("or", 32'h003160B3, 32'h0040_000C);
        pop_check("andi", 32'h0F02F213, 32'h0040_0010);

        // Push and pop in the same cycle when not full: count unchanged
        send(OPSLT, 1'b0, 5'd7, 5'd8, 5'd9, 20'd0);
        set_req(OPADD, 1'b0, 5'd3, 5'd1, 5'd2, 20'd0);
        iReqValid = 1'b1;
        iOutReady = 1'b1;
        tick();
        iReqValid = 1'b0;
        iOutReady = 1'b0;
        pop_check("pushpop", 32'h002081B3, 32'h0040_0018);
        check("pushpop_empty", {31'd0, oOutValid}, 32'd0);

        // Unsupported request
        start_pulse();
        send(OPSUB, 1'b1, 5'd1, 5'd2, 5'd3, 20'd5);
        check("err_pulse", {31'd0, oErr}, 32'd1);
        check("err_count1", {24'd0, oErrCount}, 32'd1);
        check("err_nopush", {31'd0, oOutValid}, 32'd0);
        tick();
        check("err_pulse_end", {31'd0, oErr}, 32'd0);
        send(OPADD, 1'b0, 5'd3, 5'd1, 5'd2, 20'd0);
        pop_check("after_err", 32'h002081B3, 32'h0040_0000);

        // Saturation: 300 more unsupported requests on top of the one above
        set_req(OPNULL, 1'b0, 5'd0, 5'd0, 5'd0, 20'd0);
        iReqValid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        iReqValid = 1'b0;
        check("err_sat", {24'd0, oErrCount}, 32'd255);
        check("err_sat_nopush", {31'd0, oOutValid}, 32'd0);

        // Fill the FIFO
        start_pulse();
        check("start_clr_cnt", {24'd0, oErrCount}, 32'd0);
        for (int i = 1; i <= 4; i++) send(OPADD, 1'b0, 5'(i), 5'd1, 5'd2, 20'd0);
        check("full_ready", {31'd0, oReqReady}, 32'd0);
        check("full_head", oWord, 32'h002080B3);
        tick();
        check("full_head_stable", oWord, 32'h002080B3);
        check("full_addr_stable", oAddr, 32'h0040_0000);
        set_req(OPADD, 1'b0, 5'd9, 5'd1, 5'd2, 20'd0);
        iReqValid = 1'b1;
        iOutReady = 1'b1;
        tick();
        iReqValid = 1'b0;
        iOutReady = 1'b0;
        pop_check("full_w2", 32'h00208133, 32'h0040_0004);
        pop_check("full_w3", 32'h002081B3, 32'h0040_0008);
        pop_check("full_w4", 32'h00208233, 32'h0040_000C);
        check("full_nobypass", {31'd0, oOutValid}, 32'd0);

        // iStart flush with a concurrent request that must be dropped
        for (int i = 0; i < 3; i++) send(OPOR, 1'b0, 5'd1, 5'd2, 5'd3, 20'd0);
        set_req(OPAND, 1'b0, 5'd1, 5'd1, 5'd1, 20'd0);
        iReqValid = 1'b1;
        iStart = 1'b1;
        #2 check("start_ready", {31'd0, oReqReady}, 32'd1);
        tick();
        iReqValid = 1'b0;
        iStart = 1'b0;
        check("start_flush", {31'd0, oOutValid}, 32'd0);
        send(OPADD, 1'b0, 5'd3, 5'd1, 5'd2, 20'd0);
        pop_check("start_addr", 32'h002081B3, 32'h0040_0000);

        // Async reset mid-stream
        send(OPOR, 1'b0, 5'd1, 5'd2, 5'd3, 20'd0);
        send(OPOR, 1'b0, 5'd1, 5'd2, 5'd3, 20'd0);
        #2 iRSTn = 1'b0;
        #1 check("arst_flush", {31'd0, oOutValid}, 32'd0);
        iRSTn = 1'b1;
        tick();
        send(OPADD, 1'b0, 5'd3, 5'd1, 5'd2, 20'd0);
        pop_check("arst_addr", 32'h002081B3, 32'h0040_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
